// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction fetch front end:
//   - fetch_state_t : encoding of the fetch sequencer states
//   - NOOP          : instruction word placed in IR for a squashed slot
//   - opcode field positions, and the branch-offset / jump-target field widths
//     that follow from them
// ----------------------------------------------------------------------------
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,   // first edge after reset release, no fetch yet
      ST_RUN    = 2'd1,   // one instruction issued into IR per cycle
      ST_STALL  = 2'd2,   // PC/IR frozen by the decode stage
      ST_SQUASH = 2'd3    // bubble following a redirect
   } fetch_state_t;

   localparam logic [31:0] NOOP = 32'h0000_0000;

   // Opcode occupies the top six bits of every instruction word.
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;

   // Immediate fields carried alongside the instruction in IR.
   localparam int BR_OFF_W   = 16;
   localparam int JUMP_TGT_W = OPCODE_LSB;   // jump target fills everything below the opcode

endpackage : cpu_pkg

// File: rtl/next_pc_sel.sv
// ----------------------------------------------------------------------------
// next_pc_sel
// Purely combinational next-PC selection for the fetch unit.
// Computes the branch and jump targets relative to the instruction in IR and
// chooses between them and the sequential PC+1.
//
// Ports:
//   i_pc            current fetch address (word index)
//   i_irpc          address of the instruction held in IR
//   i_ir_valid      IR holds a real instruction; redirects are ignored otherwise
//   i_branch        IR instruction is a taken branch
//   i_branch_offset signed word offset of that branch
//   i_jump          IR instruction is a jump (wins over i_branch)
//   i_jump_target   absolute word target of that jump (low bits)
//   o_redirect      a redirect is being taken this cycle
//   o_next_pc       address to fetch next
// ----------------------------------------------------------------------------
module next_pc_sel
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] i_pc,
   input  logic [DATA_WIDTH-1:0] i_irpc,
   input  logic                  i_ir_valid,
   input  logic                  i_branch,
   input  logic [BR_OFF_W-1:0]   i_branch_offset,
   input  logic                  i_jump,
   input  logic [JUMP_TGT_W-1:0] i_jump_target,
   output logic                  o_redirect,
   output logic [DATA_WIDTH-1:0] o_next_pc
);

   logic [DATA_WIDTH-1:0] w_seq_pc;
   logic [DATA_WIDTH-1:0] w_irpc_inc;
   logic [DATA_WIDTH-1:0] w_branch_tgt;
   logic [DATA_WIDTH-1:0] w_jump_tgt;

   assign w_seq_pc   = i_pc + DATA_WIDTH'(1);
   assign w_irpc_inc = i_irpc + DATA_WIDTH'(1);

   // Offset is relative to the slot after the branch; the sum wraps freely.
   assign w_branch_tgt = w_irpc_inc
                       + {{(DATA_WIDTH-BR_OFF_W){i_branch_offset[BR_OFF_W-1]}}, i_branch_offset};

   // Jump keeps the region bits of the following slot and replaces the rest.
   assign w_jump_tgt = {w_irpc_inc[DATA_WIDTH-1:JUMP_TGT_W], i_jump_target};

   // A squashed or empty IR cannot redirect, so stale Jump/Branch are harmless.
   assign o_redirect = i_ir_valid & (i_jump | i_branch);

   always_comb begin
      o_next_pc = w_seq_pc;
      if (o_redirect) begin
         o_next_pc = i_jump ? w_jump_tgt : w_branch_tgt;
      end
   end

endmodule : next_pc_sel

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Single-issue instruction fetch stage with word addressing. Drives PC to
// instruction memory, registers the returned word into IR together with its
// address, and handles stalls and branch/jump redirects. A redirect squashes
// the in-flight fetch, leaving a one-cycle NOOP bubble in IR.
//
// Ports:
//   Clk          rising-edge clock
//   Reset_n      asynchronous active-low reset
//   Stall        hold PC, IR, IRPC, IRValid and FetchCount
//   Branch       instruction in IR is a taken branch
//   BranchOffset signed word offset for Branch
//   Jump         instruction in IR is a jump (priority over Branch)
//   JumpTarget   absolute word target for Jump
//   PC           fetch address to instruction memory
//   InstrIn      instruction word for PC (combinational memory read)
//   IR           registered instruction to decode
//   IRPC         address of the instruction in IR
//   IRValid      IR holds a real, non-squashed instruction
//   FetchCount   number of valid instructions issued into IR (wraps)
// ----------------------------------------------------------------------------
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  Stall,
   input  logic                  Branch,
   input  logic [BR_OFF_W-1:0]   BranchOffset,
   input  logic                  Jump,
   input  logic [JUMP_TGT_W-1:0] JumpTarget,
   output logic [DATA_WIDTH-1:0] PC,
   input  logic [DATA_WIDTH-1:0] InstrIn,
   output logic [DATA_WIDTH-1:0] IR,
   output logic [DATA_WIDTH-1:0] IRPC,
   output logic                  IRValid,
   output logic [DATA_WIDTH-1:0] FetchCount
);

   fetch_state_t          r_state;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_ir;
   logic [DATA_WIDTH-1:0] r_irpc;
   logic                  r_ir_valid;
   logic [DATA_WIDTH-1:0] r_fetch_count;

   logic                  w_redirect;
   logic [DATA_WIDTH-1:0] w_next_pc;

   next_pc_sel #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_next_pc_sel (
      .i_pc            (r_pc),
      .i_irpc          (r_irpc),
      .i_ir_valid      (r_ir_valid),
      .i_branch        (Branch),
      .i_branch_offset (BranchOffset),
      .i_jump          (Jump),
      .i_jump_target   (JumpTarget),
      .o_redirect      (w_redirect),
      .o_next_pc       (w_next_pc)
   );

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would let r_irpc see the already-updated r_pc.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         // Reset also wipes any pending stall or squash context.
         r_state       <= ST_BOOT;
         r_pc          <= RESET_PC;
         r_ir          <= DATA_WIDTH'(NOOP);
         r_irpc        <= '0;
         r_ir_valid    <= 1'b0;
         r_fetch_count <= '0;
      end else begin
         case (r_state)
            ST_BOOT: begin
               // Memory gets one full cycle to return the word at RESET_PC.
               r_state <= ST_RUN;
            end
            default: begin
               // Redirect beats Stall; Stall beats a sequential fetch.
               if (w_redirect) begin
                  r_pc       <= w_next_pc;
                  r_ir       <= DATA_WIDTH'(NOOP);
                  r_ir_valid <= 1'b0;
                  r_state    <= ST_SQUASH;
               end else if (Stall) begin
                  r_state <= ST_STALL;
               end else begin
                  r_ir          <= InstrIn;
                  r_irpc        <= r_pc;
                  r_ir_valid    <= 1'b1;
                  r_pc          <= w_next_pc;
                  r_fetch_count <= r_fetch_count + DATA_WIDTH'(1);
                  r_state       <= ST_RUN;
               end
            end
         endcase
      end
   end

   assign PC         = r_pc;
   assign IR         = r_ir;
   assign IRPC       = r_irpc;
   assign IRValid    = r_ir_valid;
   assign FetchCount = r_fetch_count;

endmodule : fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the PC, instruction and counter width.
REQ-002 SHALL have parameter RESET_PC, default 0, the PC value loaded at reset; it is a word index.
REQ-003 SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 SHALL have port Stall, input, 1 bit: hold PC and IR.
REQ-006 SHALL have port Branch, input, 1 bit: the instruction in IR is a taken branch.
REQ-007 SHALL have port BranchOffset, input, 16 bits: signed word offset of the branch in IR.
REQ-008 SHALL have port Jump, input, 1 bit: the instruction in IR is a jump.
REQ-009 SHALL have port JumpTarget, input, 26 bits: absolute word target of the jump in IR.
REQ-010 SHALL have port PC, output, DATA_WIDTH: the fetch address driven to instruction memory.
REQ-011 SHALL have port InstrIn, input, DATA_WIDTH: instruction returned combinationally for PC.
REQ-012 SHALL have port IR, output, DATA_WIDTH: registered instruction to decode.
REQ-013 SHALL have port IRPC, output, DATA_WIDTH: PC of the instruction in IR.
REQ-014 SHALL have port IRValid, output, 1 bit: IR holds a real, non-squashed instruction.
REQ-015 SHALL have port FetchCount, output, DATA_WIDTH: count of valid instructions issued into IR.

Function
REQ-016 SHALL use word addressing: sequential next PC = PC+1.
REQ-017 SHALL compute branch target = IRPC + 1 + sign-extend(BranchOffset); arithmetic modulo 2^DATA_WIDTH, wrap-around allowed.
REQ-018 SHALL compute jump target = {bits DATA_WIDTH-1:26 of IRPC+1, JumpTarget}.
REQ-019 SHALL, in state RUN, load IR<=InstrIn, IRPC<=PC, IRValid<=1, PC<=PC+1, FetchCount+1 each cycle.
REQ-020 SHALL, when Jump or Branch is sampled high with IRValid=1, load PC<=target, load IR<=0 (NOOP), IRValid<=0, and not increment FetchCount; this squashes the in-flight fetch with a 1-cycle bubble.
REQ-021 SHALL give Jump priority over Branch when both are asserted.
REQ-022 SHALL ignore Jump and Branch while IRValid=0.
REQ-023 SHALL give a redirect priority over Stall; otherwise Stall=1 holds PC, IR, IRPC, IRValid and FetchCount unchanged.
REQ-024 SHALL implement states BOOT, RUN, STALL and SQUASH; transitions are:
- BOOT->RUN after the first edge following reset release.
- RUN/STALL->SQUASH on redirect.
- RUN->STALL on Stall.
- STALL->RUN on !Stall.
- SQUASH->RUN, or SQUASH->STALL if Stall.
REQ-025 SHALL, in BOOT, present PC=RESET_PC with IRValid=0 and perform no IR load.
REQ-026 SHALL let FetchCount wrap from all-ones to 0.
REQ-027 SHALL make redirect-to-self (target equals IRPC) legal and refetch that instruction.

Reset
REQ-028 SHALL, with Reset_n low, asynchronously force PC=RESET_PC, IR=0, IRPC=0, IRValid=0, FetchCount=0, state=BOOT.
REQ-029 SHALL, on reset asserted mid-stall or mid-squash, discard all pending redirect and stall context.
REQ-030 SHALL have its first valid IR appear on the second rising edge after Reset_n deasserts.

Structure
REQ-031 SHALL place the state encoding, the NOOP constant (0), and the opcode field positions in shared package cpu_pkg.
REQ-032 SHALL use one sub-module, next_pc_sel: combinational target and priority mux; all registers stay in fetch_unit.

Verification
REQ-033 Release reset with instruction memory loaded with the 16-word test program -> IRPC sequence 0,1,2,... with IRValid=1 from the second edge; FetchCount=7 after 7 valid issues.
REQ-034 IR holds the word at 11 (IRPC=11), Branch=1, BranchOffset=0xFFFD -> next cycle IR=0, IRValid=0, PC=9; the following cycle IRPC=9.
REQ-035 IRPC=12, Jump=1, JumpTarget=15 -> words 13 and 14 never reach IR with IRValid=1; next valid IRPC=15.
REQ-036 Stall=1 for 3 cycles at PC=5 -> PC, IR and FetchCount frozen; release resumes at IRPC=5 with no duplicates.
REQ-037 Stall=1 and Branch=1 together -> redirect taken, bubble inserted; Jump=1 and Branch=1 together -> jump target used.
REQ-038 Reset_n pulsed low mid-SQUASH -> all outputs return to reset values immediately, then restart at RESET_PC.
